// File: rtl/fir_frame_sequencer.sv
// Frame sequencer that streams a sample RAM through the FIR core and writes the results back in order.
// Optional abort_i port and abort logic are built when FIR_SEQ_ABORT_EN is defined.
module fir_frame_sequencer #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int LAT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [AW:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [DW-1:0] rd_data_i,
    output logic [DW-1:0] fir_in_o,
    input  logic [DW-1:0] fir_out_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [DW-1:0] wr_data_o
`ifdef FIR_SEQ_ABORT_EN
    ,
    input  logic          abort_i
`endif
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [AW:0]             len_q, len_d;
    logic [AW:0]             rd_cnt_q, rd_cnt_d;
    logic [LAT:0]            vld_q, vld_d;
    logic [LAT:0][AW-1:0]    idx_q, idx_d;
    logic [AW:0]             len_sat;
    logic                    feed;
    logic                    abort;
    logic                    abort_hit;

`ifdef FIR_SEQ_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign len_sat   = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    assign feed      = (state_q == FEED);
    assign abort_hit = abort && ((state_q == FEED) || (state_q == DRAIN));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i) begin
                    len_d    = len_sat;
                    rd_cnt_d = '0;
                    state_d  = (len_sat == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                rd_cnt_d = rd_cnt_q + ONE;
                if (rd_cnt_q == len_q - ONE) state_d = DRAIN;
            end
            DRAIN: begin
                // The last result is in the final stage; DONE lands right after its write.
                if (vld_q[LAT-1:0] == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_hit) state_d = IDLE;
    end

    // Each stage tags a sample with its RAM index so the result lands at the same address.
    always_comb begin
        vld_d = {vld_q[LAT-1:0], feed};
        idx_d = {idx_q[LAT-1:0], rd_cnt_q[AW-1:0]};
        if (abort_hit) vld_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            rd_cnt_q <= '0;
            vld_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_cnt_q <= rd_cnt_d;
            vld_q    <= vld_d;
            idx_q    <= idx_d;
        end
    end

    assign busy_o    = (state_q == FEED) || (state_q == DRAIN);
    assign done_o    = (state_q == DONE);
    assign rd_en_o   = feed;
    assign rd_addr_o = feed ? rd_cnt_q[AW-1:0] : '0;
    assign fir_in_o  = vld_q[0] ? rd_data_i : '0;
    assign wr_en_o   = vld_q[LAT];
    assign wr_addr_o = vld_q[LAT] ? idx_q[LAT] : '0;
    assign wr_data_o = vld_q[LAT] ? fir_out_i : '0;

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Directed bench for fir_frame_sequencer: FIR replaced by an LAT-cycle delay line, sample RAM holds 11*(i+1).
module tb_fir_frame_sequencer;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [AW:0]   len_i;
    logic          busy_o, done_o, rd_en_o, wr_en_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [DW-1:0] rd_data_i, fir_in_o, fir_out_i, wr_data_o;
    logic          abort_i;

    fir_frame_sequencer #(.DW(DW), .AW(AW), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .len_i     (len_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .fir_in_o  (fir_in_o),
        .fir_out_i (fir_out_i),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o)
`ifdef FIR_SEQ_ABORT_EN
        ,
        .abort_i   (abort_i)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] dl  [LAT];
    int            wr_seen = 0;
    int            done_seen = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    always @(posedge clk) begin
        rd_data_i <= rd_en_o ? ram[rd_addr_o] : 32'hdead_beef;
        dl[0] <= fir_in_o;
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
        if (wr_en_o) wr_seen <= wr_seen + 1;
        if (done_o) done_seen <= done_seen + 1;
    end
    assign fir_out_i = dl[LAT-1];

    typedef struct {
        int len_in;
        int eff;
        int done_off;
        int pulse_at;
        bit chain;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [DW-1:0] ram_val(input int i);
        return DW'(11 * (i + 1));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_busy"}, 32'(busy_o), 0);
        chk({nm, "_done"}, 32'(done_o), 0);
        chk({nm, "_rd_en"}, 32'(rd_en_o), 0);
        chk({nm, "_wr_en"}, 32'(wr_en_o), 0);
        chk({nm, "_rd_addr"}, 32'(rd_addr_o), 0);
        chk({nm, "_wr_addr"}, 32'(wr_addr_o), 0);
        chk({nm, "_fir_in"}, fir_in_o, 0);
        chk({nm, "_wr_data"}, wr_data_o, 0);
    endtask

    task automatic launch(input int len);
        start_i = 1'b1;
        len_i   = (AW+1)'(len);
    endtask

    // Cycle offsets are relative to the cycle T in which start_i was sampled.
    task automatic run_body(input vec_t v, input int next_len);
        for (int c = 1; c <= v.done_off; c++) begin
            logic e_rd, e_fi, e_wr;
            cyc();
            if (c == 1) start_i = 1'b0;
            if (v.pulse_at != 0 && c == v.pulse_at) begin start_i = 1'b1; len_i = 6'd8; end
            if (v.pulse_at != 0 && c == v.pulse_at + 1) start_i = 1'b0;
            e_rd = (c <= v.eff);
            e_fi = (c >= 2) && (c <= v.eff + 1);
            e_wr = (c >= LAT + 2) && (c <= LAT + 1 + v.eff);
            chk("rd_en", 32'(rd_en_o), 32'(e_rd));
            if (e_rd) chk("rd_addr", 32'(rd_addr_o), c - 1);
            chk("fir_in", fir_in_o, e_fi ? ram_val(c - 2) : 0);
            chk("wr_en", 32'(wr_en_o), 32'(e_wr));
            if (e_wr) begin
                chk("wr_addr", 32'(wr_addr_o), c - LAT - 2);
                chk("wr_data", wr_data_o, ram_val(c - LAT - 2));
            end
            chk("done", 32'(done_o), 32'(c == v.done_off));
            chk("busy", 32'(busy_o), 32'(c < v.done_off));
        end
        if (next_len >= 0) begin
            launch(next_len);
        end else begin
            cyc();
            chk("post_done", 32'(done_o), 0);
            chk("post_busy", 32'(busy_o), 0);
            chk("post_rd_en", 32'(rd_en_o), 0);
        end
    endtask

    initial begin
        int  wr_base, done_base;
        bit  launched;
        for (int i = 0; i < 2**AW; i++) ram[i] = ram_val(i);
        tbl[0] = '{len_in: 4,  eff: 4,  done_off: 14, pulse_at: 0, chain: 0};
        tbl[1] = '{len_in: 32, eff: 32, done_off: 42, pulse_at: 0, chain: 0};
        tbl[2] = '{len_in: 40, eff: 32, done_off: 42, pulse_at: 0, chain: 0};
        tbl[3] = '{len_in: 0,  eff: 0,  done_off: 1,  pulse_at: 0, chain: 0};
        tbl[4] = '{len_in: 1,  eff: 1,  done_off: 11, pulse_at: 0, chain: 0};
        tbl[5] = '{len_in: 4,  eff: 4,  done_off: 14, pulse_at: 5, chain: 0};
        tbl[6] = '{len_in: 2,  eff: 2,  done_off: 12, pulse_at: 0, chain: 1};
        tbl[7] = '{len_in: 3,  eff: 3,  done_off: 13, pulse_at: 0, chain: 0};

        reset = 1'b0; start_i = 1'b0; len_i = '0; abort_i = 1'b0;
        repeat (2) cyc();
        chk_quiet("reset");
        reset = 1'b1;
        cyc();

        launched = 0;
        for (int i = 0; i < 8; i++) begin
            wr_base = wr_seen;
            if (!launched) launch(tbl[i].len_in);
            run_body(tbl[i], (tbl[i].chain && i < 7) ? tbl[i+1].len_in : -1);
            launched = tbl[i].chain;
            if (!tbl[i].chain) chk("wr_count", 32'(wr_seen - wr_base), 32'(tbl[i].eff));
        end

        // Reset low at T+3 of a len=8 frame: outputs clear and the frame never completes.
        wr_base = wr_seen; done_base = done_seen;
        launch(8);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            if (c == 1) start_i = 1'b0;
        end
        chk("rst_mid_busy_before", 32'(busy_o), 1);
        reset = 1'b0;
        cyc();
        chk_quiet("rst_mid");
        reset = 1'b1;
        repeat (20) cyc();
        chk("rst_mid_no_wr", 32'(wr_seen - wr_base), 0);
        chk("rst_mid_no_done", 32'(done_seen - done_base), 0);
        chk_quiet("rst_mid_after");

`ifdef FIR_SEQ_ABORT_EN
        wr_base = wr_seen; done_base = done_seen;
        launch(8);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c == 1) start_i = 1'b0;
        end
        chk("abort_rd_before", 32'(rd_en_o), 1);
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_rd_en", 32'(rd_en_o), 0);
        repeat (20) cyc();
        chk("abort_no_wr", 32'(wr_seen - wr_base), 0);
        chk("abort_no_done", 32'(done_seen - done_base), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
